dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
//  Memory-side responder for the pipelined CPU's data port: serves word reads and writes
//  issued by a CPU or cache-side initiator over a valid/ready request channel and a
//  valid/ready response channel. Models a multi-cycle data RAM with configurable access
//  latency and address error detection. The initiator's memory stage stalls on it.
//  One request is outstanding at a time.
// PARAMETERS
//  DEPTH    256  number of 32-bit words in the array (power of 2, >=4)
//  LATENCY  2    cycles from request accept edge to rsp_valid_o high (>=1)
// PORTS
//  clk_i         in   1   clock, rising edge
//  rst_i         in   1   asynchronous reset, active-low
//  req_valid_i   in   1   request present
//  req_ready_o   out  1   responder can accept a request
//  req_we_i      in   1   1=write, 0=read
//  req_addr_i    in   32  byte address, must be word aligned
//  req_wdata_i   in   32  write data
//  rsp_valid_o   out  1   response present
//  rsp_ready_i   in   1   initiator takes response
//  rsp_rdata_o   out  32  read data (0 for writes and errors)
//  rsp_err_o     out  1   misaligned or out-of-range address
// BEHAVIOUR
//  Reset (rst_i=0, async): state=IDLE, req_ready_o=1, rsp_valid_o=0, rsp_rdata_o=0,
//   rsp_err_o=0, latency counter=0. Array contents are not reset.
//  FSM IDLE -> BUSY -> RESP -> IDLE.
//   IDLE: req_ready_o=1. On edge with req_valid_i=1, the request is accepted.
//    If LATENCY==1, go to RESP. Otherwise go to BUSY with cnt=LATENCY-1.
//   BUSY: req_ready_o=0. cnt decrements each edge. When cnt reaches 1, go to RESP on that edge.
//   RESP: rsp_valid_o=1. rsp_* stay stable until the edge with rsp_ready_i=1, then go to IDLE.
//  Timing: if accepted at edge T, rsp_valid_o rises after edge T+LATENCY-1, which gives
//   LATENCY cycles of latency. Back-to-back throughput is at best one request per LATENCY+1 cycles.
//   req_ready_o is 0 in the cycle where a response handshake completes. There is no same-cycle re-accept.
//  Access: the array is indexed by req_addr_i[2+log2(DEPTH)-1:2].
//   The operation is performed at the accept edge.
//   A write updates the array at that edge. A read captures the word into a response register at that edge.
//   A read that follows a completed write to the same address returns the new data.
//  Error: if req_addr_i[1:0]!=0, or req_addr_i>=4*DEPTH, then rsp_err_o=1 and rsp_rdata_o=0.
//   An erroring write does not modify the array. The error is reported with the same latency.
//  Writes return rsp_rdata_o=0, rsp_err_o=0 when valid.
//  Request inputs are ignored while not in IDLE. rsp_ready_i is ignored outside RESP.
//  Reset mid-operation: any pending response is dropped and the FSM returns to IDLE.
//   A write already accepted remains committed.
//  Counter width: $clog2(LATENCY+1). No wrap occurs because the counter is reloaded only in IDLE.
// TESTING
//  1. LATENCY=2. Write 0xDEADBEEF @0x10, then read @0x10.
//     Expect rsp_valid 2 cycles after each accept, and read rdata=0xDEADBEEF, err=0.
//  2. LATENCY=1. Read @0x4 while rsp_ready_i is held 0 for 5 cycles.
//     Expect rsp_valid=1 and rdata stable for 5 cycles, req_ready=0, then IDLE after the handshake.
//  3. Read @0x3 (misaligned) and read @0x400 with DEPTH=256.
//     Expect err=1 and rdata=0 for both. Then write 0x1234 @0x400 and re-read @0x3FC.
//     Expect the write did not disturb word 255.
//  4. Assert rst_i=0 asynchronously in BUSY after a write accept of 0x55 @0x8.
//     Expect rsp_valid=0 and req_ready=1 immediately. A later read @0x8 returns 0x55.
//  5. Hold req_valid=1 with changing addr during BUSY and RESP.
//     Expect only the first request to be served and the others ignored until req_ready=1.
//  6. Random sequence of 1000 reads and writes against a scoreboard with random rsp_ready stalls.
//     Expect every response to match the model and no accept while req_ready=0.

Source files
------------

// File: rtl/dmem_responder.sv
// Data-memory responder: single-outstanding valid/ready word access with fixed
// access latency and address error detection for the CPU data port.
module dmem_responder #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(LATENCY + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          err_q, err_d;

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] idx;
    logic          addr_err;
    logic          mem_we;

    // Any address bit above the array span marks the access as out of range.
    assign idx      = req_addr_i[AW+1:2];
    assign addr_err = (req_addr_i[1:0] != 2'b00) || (req_addr_i[31:AW+2] != '0);
    assign mem_we   = (state_q == IDLE) && req_valid_i && req_we_i && !addr_err;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can
        // leave a signal unassigned and infer a latch.
        state_d     = state_q;
        cnt_d       = cnt_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        req_ready_o = 1'b0;
        rsp_valid_o = 1'b0;

        case (state_q)
            IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    rdata_d = (req_we_i || addr_err) ? 32'h0 : mem[idx];
                    err_d   = addr_err;
                    if (LATENCY == 1) begin
                        state_d = RESP;
                    end else begin
                        state_d = BUSY;
                        cnt_d   = CW'(LATENCY - 1);
                    end
                end
            end
            BUSY: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                rsp_valid_o = 1'b1;
                if (rsp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of process ordering.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // NOTE: the array has no reset so it maps onto RAM; a write accepted before
    // a reset stays committed.
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem[idx] <= req_wdata_i;
        end
    end

    assign rsp_rdata_o = rdata_q;
    assign rsp_err_o   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: scoreboard-checked LATENCY=2 instance plus a
// LATENCY=1 instance for response-hold timing.
module tb_dmem_responder;

    localparam int LAT = 2;

    logic        clk_i;
    logic        rst_i;
    logic        req_valid_i, req_ready_o, req_we_i;
    logic [31:0] req_addr_i, req_wdata_i;
    logic        rsp_valid_o, rsp_ready_i, rsp_err_o;
    logic [31:0] rsp_rdata_o;

    logic        req_valid1, req_ready1, req_we1;
    logic [31:0] req_addr1, req_wdata1;
    logic        rsp_valid1, rsp_ready1, rsp_err1;
    logic [31:0] rsp_rdata1;

    dmem_responder #(.DEPTH(256), .LATENCY(LAT)) u_dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
        .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o)
    );

    dmem_responder #(.DEPTH(256), .LATENCY(1)) u_dut1 (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid1), .req_ready_o(req_ready1), .req_we_i(req_we1),
        .req_addr_i(req_addr1), .req_wdata_i(req_wdata1),
        .rsp_valid_o(rsp_valid1), .rsp_ready_i(rsp_ready1),
        .rsp_rdata_o(rsp_rdata1), .rsp_err_o(rsp_err1)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          acc;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model [256];
    int          cyc = 0;
    int          cmp_cnt = 0;
    int          err_cnt = 0;
    bit          rsp_rand = 1'b0;
    bit          seen = 1'b0;

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference behaviour at the accept edge: expected response and array update.
    task automatic model_accept(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        exp_t e;
        logic bad;
        bad     = (addr[1:0] != 2'b00) || (addr >= 32'h400);
        e.err   = bad;
        e.rdata = (we || bad) ? 32'h0 : model[addr[9:2]];
        e.acc   = cyc + 1;
        if (we && !bad) model[addr[9:2]] = wdata;
        sb.push_back(e);
    endtask

    task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        int n;
        @(negedge clk_i);
        req_valid_i = 1'b1;
        req_we_i    = we;
        req_addr_i  = addr;
        req_wdata_i = wdata;
        n = 0;
        while (!req_ready_o && n < 200) begin
            @(negedge clk_i);
            n++;
        end
        check("accept_wait", (n < 200) ? 32'd1 : 32'd0, 32'd1);
        if (n < 200) model_accept(we, addr, wdata);
        @(posedge clk_i);
        #1;
        req_valid_i = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || rsp_valid_o) && n < 500) begin
            @(negedge clk_i);
            n++;
        end
        check("drain_empty", sb.size(), 0);
    endtask

    // Monitor: compares every presented response against the scoreboard head.
    always @(negedge clk_i) begin
        if (!rst_i) begin
            sb.delete();
            seen = 1'b0;
        end else if (rsp_valid_o) begin
            if (sb.size() == 0) begin
                cmp_cnt++;
                err_cnt++;
                $display("FAIL unexpected_rsp: got rdata 0x%08h err %0b with no request pending (cycle %0d)",
                         rsp_rdata_o, rsp_err_o, cyc);
            end else begin
                if (!seen) begin
                    seen = 1'b1;
                    check("latency", 32'(cyc - sb[0].acc), 32'(LAT - 1));
                end
                check("rsp_rdata", rsp_rdata_o, sb[0].rdata);
                check("rsp_err", rsp_err_o, sb[0].err);
                check("req_ready_in_resp", req_ready_o, 0);
                if (rsp_ready_i) begin
                    void'(sb.pop_front());
                    seen = 1'b0;
                end
            end
        end
    end

    initial begin
        rsp_ready_i = 1'b1;
        forever begin
            @(posedge clk_i);
            #1;
            rsp_ready_i = rsp_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] a;
        int          r;
        req_valid_i = 1'b0; req_we_i = 1'b0; req_addr_i = '0; req_wdata_i = '0;
        req_valid1  = 1'b0; req_we1  = 1'b0; req_addr1  = '0; req_wdata1  = '0;
        rsp_ready1  = 1'b1;
        rst_i = 1'b1;
        #2 rst_i = 1'b0;
        #2;
        check("rst_req_ready", req_ready_o, 1);
        check("rst_rsp_valid", rsp_valid_o, 0);
        check("rst_rdata", rsp_rdata_o, 0);
        check("rst_err", rsp_err_o, 0);
        repeat (2) @(negedge clk_i);
        rst_i = 1'b1;

        // Write then read-back with two-cycle latency.
        issue(1'b1, 32'h10, 32'hDEADBEEF);
        issue(1'b0, 32'h10, 32'h0);
        drain();

        // LATENCY=1 instance: response held under backpressure.
        @(negedge clk_i);
        req_valid1 = 1'b1; req_we1 = 1'b1; req_addr1 = 32'h4; req_wdata1 = 32'hA5A50004;
        check("l1_ready_idle", req_ready1, 1);
        @(posedge clk_i); #1 req_valid1 = 1'b0;
        @(negedge clk_i);
        check("l1_wr_valid", rsp_valid1, 1);
        check("l1_wr_rdata", rsp_rdata1, 0);
        check("l1_wr_err", rsp_err1, 0);
        @(negedge clk_i);
        check("l1_wr_done", rsp_valid1, 0);
        rsp_ready1 = 1'b0;
        req_valid1 = 1'b1; req_we1 = 1'b0; req_addr1 = 32'h4;
        @(posedge clk_i); #1 req_valid1 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            check("l1_hold_valid", rsp_valid1, 1);
            check("l1_hold_rdata", rsp_rdata1, 32'hA5A50004);
            check("l1_hold_ready", req_ready1, 0);
        end
        rsp_ready1 = 1'b1;
        @(negedge clk_i);
        check("l1_after_hs_valid", rsp_valid1, 0);
        check("l1_after_hs_ready", req_ready1, 1);

        // Address errors and the out-of-range write that must not alias word 0.
        issue(1'b1, 32'h0, 32'h0BADF00D);
        issue(1'b1, 32'h3FC, 32'hCAFEF00D);
        issue(1'b0, 32'h3, 32'h0);
        issue(1'b0, 32'h400, 32'h0);
        issue(1'b1, 32'h400, 32'h1234);
        issue(1'b0, 32'h3FC, 32'h0);
        issue(1'b0, 32'h0, 32'h0);
        issue(1'b1, 32'h2, 32'h77777777);
        issue(1'b0, 32'hFFFFFFFC, 32'h0);
        drain();

        // Reset while a write is in flight.
        issue(1'b1, 32'h8, 32'h55);
        #1;
        check("busy_before_rst", req_ready_o, 0);
        rst_i = 1'b0;
        #1;
        check("rst_mid_rsp_valid", rsp_valid_o, 0);
        check("rst_mid_req_ready", req_ready_o, 1);
        repeat (2) @(negedge clk_i);
        rst_i = 1'b1;
        issue(1'b0, 32'h8, 32'h0);
        drain();

        // Request held with changing contents while busy: only the first is served.
        issue(1'b1, 32'h20, 32'h11111111);
        issue(1'b1, 32'h24, 32'h22222222);
        issue(1'b1, 32'h28, 32'h33333333);
        drain();
        rsp_rand = 1'b1;
        @(negedge clk_i);
        req_valid_i = 1'b1; req_we_i = 1'b0; req_addr_i = 32'h20;
        check("hold_first_ready", req_ready_o, 1);
        model_accept(1'b0, 32'h20, 32'h0);
        @(posedge clk_i);
        #1;
        for (int k = 0; k < 60; k++) begin
            req_we_i    = 1'b1;
            req_addr_i  = (k % 2 == 0) ? 32'h24 : 32'h28;
            req_wdata_i = 32'hBAD00000 | 32'(k);
            @(negedge clk_i);
            if (req_ready_o) break;
        end
        req_valid_i = 1'b0;
        rsp_rand = 1'b0;
        drain();
        issue(1'b0, 32'h24, 32'h0);
        issue(1'b0, 32'h28, 32'h0);
        drain();

        // Random traffic over a small word window plus error addresses.
        for (int i = 0; i < 16; i++) issue(1'b1, 32'h100 + 32'(4 * i), $urandom);
        drain();
        rsp_rand = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            r = $urandom_range(0, 19);
            if (r < 16)       a = 32'h100 + 32'(4 * r);
            else if (r == 16) a = 32'h100 + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(1, 3));
            else if (r == 17) a = 32'h400 + 32'(4 * $urandom_range(0, 255));
            else if (r == 18) a = 32'hFFFFFFFC;
            else              a = 32'h3FC;
            issue(1'($urandom_range(0, 1)), a, $urandom);
        end
        drain();
        rsp_rand = 1'b0;

        repeat (3) @(negedge clk_i);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
